// File: rtl/int_to_fp_seq.sv
// int_to_fp_seq: converts a two's-complement integer into the 13-bit FP word
// {sign, exp, mantissa} (value = 0.m x 2^exp). Normalization shifts the magnitude
// left one bit per clock until its MSB is set.
//
// Handshake: a request is taken only when ready=1 and start=1 on the same rising
// edge (din is sampled on that edge). ready is high only in IDLE, so start while
// busy or in the DONE cycle is dropped, never queued. done_tick is a single-cycle
// pulse; fp/ovf are valid from that cycle and held until the next done_tick.
module int_to_fp_seq #(
  parameter int EW = 4,   // exponent width; IW must equal 2**EW
  parameter int MW = 8,   // mantissa width; MW <= IW
  parameter int IW = 16   // integer input width
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IW-1:0]     din,
  output logic              ready,
  output logic              done_tick,
  output logic [EW+MW:0]    fp,
  output logic              ovf,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // exp_cnt starts at IW; it only stays there when |din| = 2^(IW-1), which does
  // not fit the EW-bit exponent field and therefore saturates.
  localparam logic [EW:0]   EXP_INIT = (EW+1)'(IW);
  localparam logic [EW:0]   EXP_ONE  = (EW+1)'(1);
  localparam logic [IW-1:0] MAG_ONE  = IW'(1);

  state_t          r_state;
  state_t          w_next_state;
  logic            r_sign;
  logic [IW-1:0]   r_mag;
  logic [EW:0]     r_exp_cnt;
  logic [EW+MW:0]  r_fp;
  logic            r_ovf;

  logic [IW-1:0]   w_mag_in;
  logic            w_norm_done;
  logic [EW+MW:0]  w_fp_result;
  logic            w_ovf_result;

  // Magnitude of the operand; the most negative value maps to 2^(IW-1) unsigned.
  assign w_mag_in    = din[IW-1] ? (~din + MAG_ONE) : din;
  assign w_norm_done = (r_mag == '0) || r_mag[IW-1];

  assign ready     = (r_state == S_IDLE);
  assign done_tick = (r_state == S_DONE);
  assign fp        = r_fp;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: IDLE -> NORM on start, NORM loops until normalized, DONE lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_NORM;
      S_NORM:  if (w_norm_done) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Result assembly from the normalized magnitude; low bits are truncated.
  always_comb begin
    w_fp_result  = {r_sign, r_exp_cnt[EW-1:0], r_mag[IW-1 -: MW]};
    w_ovf_result = 1'b0;
    if (r_mag == '0) begin
      w_fp_result = '0;
    end else if (r_exp_cnt == EXP_INIT) begin
      w_fp_result  = '1;
      w_ovf_result = 1'b1;
    end
  end

  // Datapath: capture on accept, shift while normalizing, latch the result as DONE is entered
  // so that fp/ovf are already valid during the done_tick cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_exp_cnt <= '0;
      r_fp      <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign    <= din[IW-1];
            r_mag     <= w_mag_in;
            r_exp_cnt <= EXP_INIT;
          end
        end
        S_NORM: begin
          if (w_norm_done) begin
            r_fp  <= w_fp_result;
            r_ovf <= w_ovf_result;
          end else begin
            r_mag     <= r_mag << 1;
            r_exp_cnt <= r_exp_cnt - EXP_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
